// File: rtl/systolic_skew_feeder.sv
`default_nettype none
//==============================================================================
//  Module      : systolic_skew_feeder
//  Description : Accepts one row of LANES operands per handshake and drives
//                them onto the array edge diagonally skewed: lane i carries
//                element i delayed by i extra cycles. A small FSM drains the
//                skew pipe after the last row of a tile and pulses done when
//                the final operand reaches the far lane.
//  Revision    : 1.0  initial release
//==============================================================================
module systolic_skew_feeder #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   en_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [LANES*WIDTH-1:0] in_data_i,
    input  logic                   in_last_i,
    output logic [LANES*WIDTH-1:0] lane_out_o,
    output logic [LANES-1:0]       lane_valid_o,
    output logic                   busy_o,
    output logic                   done_o
);

    // Flush counter holds up to LANES-1; one spare bit keeps LANES==1 legal.
    localparam int CNT_W = $clog2(LANES) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              accept;

    // Rows are only taken while the tile is still open and the array advances.
    assign in_ready_o = en_i & ~reset_i & ((state_q == S_IDLE) || (state_q == S_FEED));
    assign accept     = in_valid_i & in_ready_o;
    assign busy_o     = ~reset_i & (state_q != S_IDLE);
    assign done_o     = ~reset_i & (state_q == S_DONE);

    // State and flush-counter register; en low freezes the whole tile.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else if (en_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: the flush lasts LANES-1 advancing cycles so that done
    // coincides with the last row's element leaving the deepest lane.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE, S_FEED: begin
                if (accept) begin
                    if (in_last_i) begin
                        if (LANES > 1) begin
                            state_d = S_FLUSH;
                            cnt_d   = CNT_W'(LANES - 1);
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        state_d = S_FEED;
                    end
                end
            end
            S_FLUSH: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // One delay line per lane, depth i+1; non-accept cycles inject bubbles.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] dly_data_q [0:i];
        logic [i:0]       dly_valid_q;

        // Shift the lane by one stage on every advancing cycle.
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                for (int s = 0; s <= i; s++) begin
                    dly_data_q[s] <= '0;
                end
                dly_valid_q <= '0;
            end else if (en_i) begin
                dly_data_q[0]  <= accept ? in_data_i[i*WIDTH +: WIDTH] : '0;
                dly_valid_q[0] <= accept;
                for (int s = 1; s <= i; s++) begin
                    dly_data_q[s]  <= dly_data_q[s-1];
                    dly_valid_q[s] <= dly_valid_q[s-1];
                end
            end
        end

        assign lane_out_o[i*WIDTH +: WIDTH] = dly_data_q[i];
        assign lane_valid_o[i]              = dly_valid_q[i];
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
//==============================================================================
//  Module      : tb_systolic_skew_feeder
//  Description : Directed self-checking bench for systolic_skew_feeder
//                (WIDTH=8, LANES=4) with hand-computed expected values.
//  Revision    : 1.0  initial release
//==============================================================================
module tb_systolic_skew_feeder;

    localparam int WIDTH = 8;
    localparam int LANES = 4;

    logic                   clk;
    logic                   reset;
    logic                   en;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in_data;
    logic                   in_last;
    logic [LANES*WIDTH-1:0] lane_out;
    logic [LANES-1:0]       lane_valid;
    logic                   busy;
    logic                   done;

    int n_vec;
    int n_err;

    systolic_skew_feeder #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .en_i         (en),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .in_last_i    (in_last),
        .lane_out_o   (lane_out),
        .lane_valid_o (lane_valid),
        .busy_o       (busy),
        .done_o       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: count and report.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance into the next cycle; inputs set after this apply to that cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] e_out, input logic [3:0] e_vld,
                                 input logic e_done, input logic e_busy, input logic e_rdy);
        #1;
        check_eq({tag, "_out"},   lane_out,           e_out);
        check_eq({tag, "_vld"},   {28'd0, lane_valid}, {28'd0, e_vld});
        check_eq({tag, "_done"},  {31'd0, done},       {31'd0, e_done});
        check_eq({tag, "_busy"},  {31'd0, busy},       {31'd0, e_busy});
        check_eq({tag, "_rdy"},   {31'd0, in_ready},   {31'd0, e_rdy});
    endtask

    logic [31:0] b2b_out [1:8];
    logic [3:0]  b2b_vld [1:8];
    logic [31:0] b2b_row [0:3];
    logic [31:0] gap_out [1:7];
    logic [3:0]  gap_vld [1:7];
    logic [31:0] frz_out [1:8];
    logic [3:0]  frz_vld [1:8];

    initial begin
        n_vec = 0;
        n_err = 0;

        b2b_row = '{32'h13121110, 32'h23222120, 32'h33323130, 32'h43424140};
        b2b_out = '{32'h00000010, 32'h00001120, 32'h00122130, 32'h13223140,
                    32'h23324100, 32'h33420000, 32'h43000000, 32'h00000000};
        b2b_vld = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        gap_out = '{32'h00000001, 32'h00000200, 32'h00030005, 32'h04000600,
                    32'h00070000, 32'h08000000, 32'h00000000};
        gap_vld = '{4'b0001, 4'b0010, 4'b0101, 4'b1010, 4'b0100, 4'b1000, 4'b0000};
        frz_out = '{32'h000000AA, 32'h0000BB00, 32'h0000BB00, 32'h0000BB00,
                    32'h0000BB00, 32'h00CC0000, 32'hDD000000, 32'h00000000};
        frz_vld = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b0000};

        reset    = 1'b1;
        en       = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        tick();
        #1;
        check_eq("init_rst_rdy", {31'd0, in_ready}, 32'd0);
        tick();
        reset = 1'b0;
        check_outputs("init", 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1);

        // ---- reset mid-FEED ----
        in_valid = 1'b1; in_data = 32'h11111111; in_last = 1'b0;
        tick();
        in_valid = 1'b0;
        check_outputs("feed", 32'h00000011, 4'b0001, 1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("midrst_rdy", {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        check_outputs("postrst", 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1);
        tick();
        check_outputs("postrst2", 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1);

        // ---- single row, last ----
        in_valid = 1'b1; in_data = 32'h03020100; in_last = 1'b1;
        #1;
        check_eq("single_acc_rdy", {31'd0, in_ready}, 32'd1);
        for (int k = 1; k <= 5; k++) begin
            logic [31:0] eo;
            logic [3:0]  ev;
            tick();
            in_valid = 1'b0; in_last = 1'b0;
            case (k)
                1: begin eo = 32'h00000000; ev = 4'b0001; end
                2: begin eo = 32'h00000100; ev = 4'b0010; end
                3: begin eo = 32'h00020000; ev = 4'b0100; end
                4: begin eo = 32'h03000000; ev = 4'b1000; end
                default: begin eo = 32'h00000000; ev = 4'b0000; end
            endcase
            check_outputs($sformatf("single_k%0d", k), eo, ev, k == 4, k <= 4, k == 5);
        end

        // ---- four back-to-back rows, in_valid held through FLUSH/DONE ----
        in_valid = 1'b1; in_data = b2b_row[0]; in_last = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k <= 3) begin
                in_data = b2b_row[k];
                in_last = (k == 3);
            end else if (k < 8) begin
                in_data = 32'h99999999;
                in_last = 1'b0;
            end else begin
                in_data = 32'h99999999;
                in_last = 1'b1;
            end
            check_outputs($sformatf("b2b_k%0d", k), b2b_out[k], b2b_vld[k],
                          k == 7, k <= 7, (k <= 3) || (k == 8));
        end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check_outputs("next_tile", 32'h00000099, 4'b0001, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        check_outputs("next_tile_end", 32'h0, 4'b0000, 1'b0, 1'b0, 1'b1);

        // ---- gap between rows ----
        in_valid = 1'b1; in_data = 32'h04030201; in_last = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            in_valid = (k == 1);
            in_data  = (k == 1) ? 32'h08070605 : 32'h0;
            in_last  = (k == 1);
            in_valid = (k == 1);
            if (k == 1) in_valid = 1'b0;
            if (k == 1) begin
                check_outputs("gap_k1", gap_out[1], gap_vld[1], 1'b0, 1'b1, 1'b1);
                tick();
                in_valid = 1'b1; in_data = 32'h08070605; in_last = 1'b1;
                check_outputs("gap_k2", gap_out[2], gap_vld[2], 1'b0, 1'b1, 1'b1);
                k = 2;
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
                check_outputs($sformatf("gap_k%0d", k), gap_out[k], gap_vld[k],
                              k == 6, k <= 6, k == 7);
            end
        end

        // ---- en low for three cycles during FLUSH ----
        in_valid = 1'b1; in_data = 32'hDDCCBBAA; in_last = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            in_valid = 1'b0; in_last = 1'b0;
            en = !(k >= 2 && k <= 4);
            check_outputs($sformatf("frz_k%0d", k), frz_out[k], frz_vld[k],
                          k == 7, k <= 7, k == 8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
